// File: rtl/snn_pkg.sv
// Shared widths and helpers for the 8-bit SNN tile (synaptic front end and QIF neuron).
package snn_pkg;

    localparam int I_WIDTH       = 8;
    localparam int W_WIDTH       = 8;
    localparam int N_SYN_DEFAULT = 4;
    localparam int SUM_WIDTH     = 10;
    localparam int NEXT_WIDTH    = 11;

    // Clamp a signed intermediate current into the unsigned bus range.
    function automatic logic [I_WIDTH-1:0] sat_u8(input logic signed [NEXT_WIDTH-1:0] x);
        if (x[NEXT_WIDTH-1])
            return '0;
        else if (x > 11'sd255)
            return '1;
        else
            return x[I_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/spike_edge_sync.sv
// Three-flop synchroniser for one asynchronous spike line, emitting a one-cycle
// pulse on each synchronised rising edge.
module spike_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic spike_in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= spike_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/syn_current_gen.sv
// Synaptic current accumulator: per-channel weighted spike injection plus a
// periodic exponential decay, saturated onto the unsigned I_syn bus.
module syn_current_gen
    import snn_pkg::*;
#(
    parameter int                        N_SYN       = N_SYN_DEFAULT,
    parameter int                        DECAY_SHIFT = 3,
    parameter int                        TICK_DIV    = 16,
    parameter logic signed [W_WIDTH-1:0] WEIGHT_INIT = 8'sd40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [N_SYN-1:0]   spike_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [W_WIDTH-1:0] cfg_data,
    output logic [I_WIDTH-1:0] I_syn,
    output logic               tick
);

    localparam int               CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam int               DECAY_FLOOR = 1 << DECAY_SHIFT;

    logic [N_SYN-1:0]               pulse;
    logic signed [W_WIDTH-1:0]      w [N_SYN];
    logic [CNT_W-1:0]               cnt;
    logic                           tick_now;
    logic [I_WIDTH-1:0]             dec;
    logic signed [SUM_WIDTH-1:0]    sum;
    logic signed [NEXT_WIDTH-1:0]   next_i;

    for (genvar i = 0; i < N_SYN; i++) begin : g_sync
        spike_edge_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .spike_in (spike_in[i]),
            .pulse    (pulse[i])
        );
    end

    // Addresses beyond the channel count match no register and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) w[i] <= WEIGHT_INIT;
        end else if (cfg_we) begin
            for (int i = 0; i < N_SYN; i++) begin
                if (int'(cfg_addr) == i) w[i] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (ena)
            cnt <= tick_now ? '0 : cnt + 1'b1;
    end

    assign tick_now = ena & (cnt == CNT_LAST);

    // Below the shift floor the proportional step would be zero, so step by one to reach 0.
    always_comb begin
        dec = I_syn;
        if (tick_now) begin
            if (int'(I_syn) >= DECAY_FLOOR)
                dec = I_syn - (I_syn >> DECAY_SHIFT);
            else if (I_syn != '0)
                dec = I_syn - 1'b1;
            else
                dec = '0;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (pulse[i])
                sum = sum + $signed({{(SUM_WIDTH-W_WIDTH){w[i][W_WIDTH-1]}}, w[i]});
        end
    end

    assign next_i = $signed({{(NEXT_WIDTH-I_WIDTH){1'b0}}, dec})
                  + $signed({{(NEXT_WIDTH-SUM_WIDTH){sum[SUM_WIDTH-1]}}, sum});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            I_syn <= '0;
            tick  <= 1'b0;
        end else if (ena) begin
            I_syn <= sat_u8(next_i);
            tick  <= tick_now;
        end
    end

endmodule

// File: tb/tb_syn_current_gen.sv
// Scoreboard bench for syn_current_gen: stimulus queues expected currents,
// a negedge monitor checks decay ticks and cycle-stamped samples.
module tb_syn_current_gen;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        logic       tk;
        string      name;
    } pt_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] spike_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] I_syn;
    logic       tick;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    pt_t        pt_q[$];
    logic [7:0] tick_q[$];
    pt_t        cur;
    logic [7:0] exp_v;
    int         r, t, u, v, w;

    syn_current_gen dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .spike_in (spike_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .I_syn    (I_syn),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every tick pops one expected decayed value; stamped samples are checked on their cycle.
    always @(negedge clk) begin
        if (tick) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_tick cyc=%0d I_syn=%0d", cyc, I_syn);
            end else begin
                exp_v = tick_q.pop_front();
                if (I_syn !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL decay_tick cyc=%0d I_syn got %0d want %0d", cyc, I_syn, exp_v);
                end
            end
        end
        while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
            cur = pt_q.pop_front();
            checks++;
            if (cur.cyc < cyc) begin
                errors++;
                $display("[TB] FAIL %s missed sample cyc=%0d now=%0d", cur.name, cur.cyc, cyc);
            end else begin
                if (I_syn !== cur.val) begin
                    errors++;
                    $display("[TB] FAIL %s cyc=%0d I_syn got %0d want %0d", cur.name, cyc, I_syn, cur.val);
                end
                checks++;
                if (tick !== cur.tk) begin
                    errors++;
                    $display("[TB] FAIL %s cyc=%0d tick got %0b want %0b", cur.name, cyc, tick, cur.tk);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push_pt(input int c, input logic [7:0] val, input logic tk, input string name);
        pt_t e;
        e.cyc  = c;
        e.val  = val;
        e.tk   = tk;
        e.name = name;
        pt_q.push_back(e);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (tick_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (tick_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout pending ticks got %0d want 0", name, tick_q.size());
            tick_q.delete();
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; spike_in = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        step(); step();
        check_output("reset_I_syn", I_syn, 8'd0);
        check_output("reset_tick", {7'b0, tick}, 8'd0);

        r = cyc; rst = 1'b0;
        push_pt(r + 15, 8'd0, 1'b0, "pre_first_tick");
        push_pt(r + 16, 8'd0, 1'b1, "first_tick");
        tick_q.push_back(8'd0);
        drain(40, "first_tick");

        // Single spike, held high, then four decay ticks.
        t = cyc; spike_in[0] = 1'b1;
        push_pt(t + 3, 8'd40, 1'b0, "single_spike");
        push_pt(t + 10, 8'd40, 1'b0, "held_spike_no_add");
        tick_q.push_back(8'd35); tick_q.push_back(8'd31);
        tick_q.push_back(8'd28); tick_q.push_back(8'd25);
        drain(100, "decay_chain");

        t = cyc; spike_in[0] = 1'b0; cfg_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_addr = 2'(i); cfg_data = 8'd100;
            step();
        end
        cfg_we = 1'b0; spike_in = 4'b1111;
        push_pt(t + 7, 8'd255, 1'b0, "sat_high");
        step_to(t + 8); spike_in = 4'b0001;
        step_to(t + 10);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_I_syn", I_syn, 8'd0);
        check_output("async_reset_tick", {7'b0, tick}, 8'd0);

        // ch0 stays high across reset: exactly one pulse at the restored weight.
        step(); r = cyc; rst = 1'b0;
        push_pt(r + 3, 8'd40, 1'b0, "post_reset_spike");
        push_pt(r + 10, 8'd40, 1'b0, "post_reset_single_pulse");
        push_pt(r + 15, 8'd40, 1'b0, "post_reset_no_early_tick");
        push_pt(r + 16, 8'd35, 1'b1, "post_reset_first_tick");
        tick_q.push_back(8'd35);
        step_to(r + 4); spike_in[0] = 1'b0;
        drain(30, "post_reset_tick");

        t = cyc; spike_in[1] = 1'b1;
        push_pt(t + 3, 8'd75, 1'b0, "write_same_cycle_old_weight");
        push_pt(t + 8, 8'd0, 1'b0, "sat_low");
        tick_q.push_back(8'd0); tick_q.push_back(8'd0);
        step_to(t + 2); cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'h80;
        step_to(t + 3); cfg_we = 1'b0; spike_in[1] = 1'b0;
        step_to(t + 5); spike_in[1] = 1'b1;
        step_to(t + 8); spike_in[1] = 1'b0;
        drain(50, "sat_low_ticks");

        u = cyc; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd5;
        step_to(u + 1); cfg_we = 1'b0; spike_in[2] = 1'b1;
        push_pt(u + 4, 8'd5, 1'b0, "small_value_load");
        tick_q.push_back(8'd4); tick_q.push_back(8'd3); tick_q.push_back(8'd2);
        tick_q.push_back(8'd1); tick_q.push_back(8'd0); tick_q.push_back(8'd0);
        step_to(u + 5); spike_in[2] = 1'b0;
        drain(120, "small_decay");

        // ch0 pulse lands on the tick edge: 80 - 10 + 40.
        v = cyc; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 8'd80;
        step_to(v + 1); cfg_we = 1'b0; spike_in[3] = 1'b1;
        push_pt(v + 4, 8'd80, 1'b0, "load_80");
        push_pt(v + 16, 8'd110, 1'b1, "decay_plus_spike");
        tick_q.push_back(8'd110);
        step_to(v + 5); spike_in[3] = 1'b0;
        step_to(v + 13); spike_in[0] = 1'b1;
        drain(30, "simultaneous");

        w = cyc; spike_in[0] = 1'b0;
        push_pt(w + 20, 8'd110, 1'b0, "ena_low_hold_mid");
        push_pt(w + 45, 8'd110, 1'b0, "ena_low_hold_end");
        push_pt(w + 55, 8'd110, 1'b0, "ena_resume_no_early_tick");
        push_pt(w + 56, 8'd97, 1'b1, "ena_resume_tick");
        tick_q.push_back(8'd97);
        step_to(w + 5);  ena = 1'b0;
        step_to(w + 6);  spike_in[2] = 1'b1;
        step_to(w + 10); spike_in[2] = 1'b0;
        step_to(w + 15); spike_in[2] = 1'b1;
        step_to(w + 20); spike_in[2] = 1'b0;
        step_to(w + 45); ena = 1'b1;
        drain(30, "ena_resume");
        step_to(cyc + 3);

        while (pt_q.size() > 0) begin
            cur = pt_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s never sampled cyc=%0d want %0d", cur.name, cur.cyc, cur.val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
